// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two W=4*NIBBLES operands one nibble per cycle
// through an external combinational 4-bit adder, LS nibble first.
// Ports: clk, rst_n (async, active-low);
//   in_valid/in_ready/in_a/in_b/in_cin : wide operand handshake;
//   out_valid/out_ready/out_sum/out_cout/out_ovf : result handshake;
//   add_a/add_b/add_cin -> adder, add_s/add_cout <- adder.
// Optional macro SUBTRACT_EN adds in_sub (A - B in two's complement).
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
`ifdef SUBTRACT_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  res_reg;
    logic          carry_reg;
    logic [CW-1:0] cnt;
    logic          last;
    logic [3:0]    b_eff;
    logic [W+3:0]  res_cat;
    logic          sub_reg;
    logic          sub_in;

`ifdef SUBTRACT_EN
    assign sub_in = in_sub;
`else
    assign sub_in  = 1'b0;
    assign sub_reg = 1'b0;
`endif

    assign last    = (cnt == CW'(NIBBLES - 1));
    assign b_eff   = sub_reg ? ~b_reg[3:0] : b_reg[3:0];
    // New sum nibble enters at the top; dropping the low 4 bits
    // of the concatenation is a right shift that works for W == 4 too.
    assign res_cat = {add_s, res_reg};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = res_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                add_a   = a_reg[3:0];
                add_b   = b_eff;
                add_cin = carry_reg;
                if (last) next_state = DONE;
            end
            DONE: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
`ifdef SUBTRACT_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        // Subtract forces the +1 of the two's complement.
                        carry_reg <= sub_in ? 1'b1 : in_cin;
                        cnt       <= '0;
`ifdef SUBTRACT_EN
                        sub_reg   <= in_sub;
`endif
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    res_reg   <= res_cat[W+3:4];
                    carry_reg <= add_cout;
                    cnt       <= cnt + 1'b1;
                    if (last) begin
                        out_cout <= add_cout;
                        // carry into msb xor carry out of msb
                        out_ovf  <= add_a[3] ^ add_b[3] ^ add_s[3] ^ add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl with a behavioural 4-bit adder
// and an arithmetic reference model of the wide add/subtract.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_cin;
`ifdef SUBTRACT_EN
    logic           in_sub;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
    logic           out_cout;
    logic           out_ovf;
    logic [3:0]     add_a;
    logic [3:0]     add_b;
    logic           add_cin;
    logic [3:0]     add_s;
    logic           add_cout;
    logic [4:0]     add_t;

    int vectors;
    int miscompares;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef SUBTRACT_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // external adder4
    always_comb begin
        add_t    = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
        add_s    = add_t[3:0];
        add_cout = add_t[4];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input int hold);
        logic [W-1:0] be;
        logic         cc;
        logic [W:0]   full;
        logic [W:0]   m;
        logic [W:0]   lo;
        logic [W:0]   one;
        longint       sr;
        longint       smax;
        logic         eovf;
        logic         cq[$];
        logic [3:0]   sq[$];
        int           n;
        be   = s ? ~b : b;
        cc   = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, cc};
        sr   = longint'($signed(a)) + longint'($signed(be)) + longint'(cc);
        smax = (64'sd1 <<< (W - 1)) - 1;
        eovf = (sr > smax) || (sr < -smax - 1);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = c;
`ifdef SUBTRACT_EN
        in_sub   = s;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_run", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 3 * NIBBLES + 4) begin
            cq.push_back(add_cin);
            sq.push_back(add_s);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(NIBBLES));
        one = 1;
        for (int i = 0; i < NIBBLES && i < cq.size(); i++) begin
            m  = (one << (4 * i)) - one;
            lo = ({1'b0, a} & m) + ({1'b0, be} & m) + {{W{1'b0}}, cc};
            check($sformatf("add_cin[%0d]", i), 32'(cq[i]),
                  32'(lo[4 * i]));
            check($sformatf("add_s[%0d]", i), 32'(sq[i]),
                  32'((full >> (4 * i)) & 15));
        end
        check("out_sum", 32'(out_sum), 32'(full[W-1:0]));
        check("out_cout", 32'(out_cout), 32'(full[W]));
        check("out_ovf", 32'(out_ovf), 32'(eovf));
        check("add_cin_done", 32'(add_cin), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_a     = W'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'(full[W-1:0]));
            check("hold_cout", 32'(out_cout), 32'(full[W]));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_cin      = 1'b0;
`ifdef SUBTRACT_EN
        in_sub      = 1'b0;
`endif
        out_ready   = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 5);
        run_op(16'h000F, 16'h0000, 1'b1, 1'b0, 0);

        // abort an operation after two RUN cycles
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(out_sum), 32'd0);
        check("abort_cout", 32'(out_cout), 32'd0);
        check("abort_ovf", 32'(out_ovf), 32'd0);
        check("abort_add_a", 32'(add_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef SUBTRACT_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
`endif

        for (int k = 0; k < 20; k++) begin
            logic s;
            s = 1'b0;
`ifdef SUBTRACT_EN
            s = 1'($urandom);
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), s,
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
